// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the time-multiplexed channel mixer.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCUM  = 2'b01,
    DIVIDE = 2'b10,
    FINISH = 2'b11
  } mix_state_t;

  typedef enum logic [1:0] {
    MIX_SUM = 2'b00,
    MIX_SAT = 2'b01,
    MIX_AVG = 2'b10
  } mix_mode_t;

  // Enabled-channel count must represent 0..n_ch inclusive.
  function automatic int cnt_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  // Wide enough that summing every channel at full scale never overflows.
  function automatic int acc_width(input int n_ch, input int sw);
    return sw + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/mixer_serial_div.sv
// Restoring divider: one quotient bit per clock, fixed DW-cycle latency after start.
module mixer_serial_div
  import mixer_pkg::*;
#(
  parameter int DW = 12,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int KW = (DW > 1) ? $clog2(DW) : 1;

  logic          run_q, run_d;
  logic [KW-1:0] step_q, step_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] quo_q, quo_d;

  logic [VW:0]   shifted;
  logic [VW:0]   diff;
  logic          fits;

  // Remainder stays below the divisor, so one extra bit covers the shifted trial value.
  assign shifted = {rem_q, quo_q[DW-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign done    = run_q && (step_q == KW'(DW - 1));
  assign quotient = quo_q;

  always_comb begin
    run_d  = run_q;
    step_d = step_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (start) begin
      run_d  = 1'b1;
      step_d = '0;
      rem_d  = '0;
      dvs_d  = divisor;
      quo_d  = dividend;
    end else if (run_q) begin
      rem_d  = fits ? diff[VW-1:0] : shifted[VW-1:0];
      quo_d  = {quo_q[DW-2:0], fits};
      step_d = step_q + KW'(1);
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_q  <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else begin
      run_q  <= run_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

endmodule

// File: rtl/mixer_seq_accum.sv
// Sequential channel mixer: snapshot on strobe, accumulate one channel per clock,
// then pass through, saturate, or average via the serial divider.
module mixer_seq_accum
  import mixer_pkg::*;
#(
  parameter  int N_CH  = 12,
  parameter  int SW    = 8,
  localparam int CW    = cnt_width(N_CH),
  localparam int ACC_W = acc_width(N_CH, SW)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               sample_strobe,
  input  logic [N_CH*SW-1:0] samples,
  input  logic [N_CH-1:0]    sample_enable,
  input  logic [1:0]         mode,
  input  logic               overrun_clr,
  output logic [ACC_W-1:0]   mix_out,
  output logic               mix_valid,
  output logic [CW-1:0]      num_signals,
  output logic               busy,
  output logic               overrun
);

  localparam int IW = $clog2(N_CH);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << SW) - 1);

  mix_state_t         state_q, state_d;
  logic [N_CH*SW-1:0] snap_q, snap_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]   mix_out_q, mix_out_d;
  logic               mix_valid_q, mix_valid_d;
  logic [CW-1:0]      num_q, num_d;
  logic               overrun_q, overrun_d;

  logic               div_start;
  logic               div_done;
  logic [ACC_W-1:0]   div_quot;
  logic [SW-1:0]      snap_arr [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign snap_arr[gi] = snap_q[gi*SW +: SW];
    end
  endgenerate

  mixer_serial_div #(
    .DW(ACC_W),
    .VW(CW)
  ) u_div (
    .clk     (clk),
    .nrst    (nrst),
    .start   (div_start),
    .dividend(acc_d),
    .divisor (cnt_d),
    .quotient(div_quot),
    .done    (div_done)
  );

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    en_d        = en_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    num_d       = num_q;
    div_start   = 1'b0;

    // A new overrun takes priority over a clear in the same cycle.
    overrun_d = overrun_q;
    if (sample_strobe && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          snap_d  = samples;
          en_d    = sample_enable;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + {{(ACC_W-SW){1'b0}}, snap_arr[idx_q]};
          cnt_d = cnt_q + CW'(1);
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_CH - 1)) begin
          idx_d = '0;
          // Counts of 0 or 1 already equal their own average; skip the divider.
          if (mode_q[1] && (cnt_d >= CW'(2))) begin
            div_start = 1'b1;
            state_d   = DIVIDE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (mode_q[1] && (cnt_q >= CW'(2))) begin
          mix_out_d = div_quot;
        end else if ((mode_q == MIX_SAT) && (acc_q > SAT_MAX)) begin
          mix_out_d = SAT_MAX;
        end else begin
          mix_out_d = acc_q;
        end
        num_d       = cnt_q;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      en_q        <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      num_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      num_q       <= num_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign num_signals = num_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mixer_seq_accum.sv
// Scoreboard bench for mixer_seq_accum: stimulus pushes expected results, a monitor checks them.
module tb_mixer_seq_accum;

  localparam int N_CH  = 12;
  localparam int SW    = 8;
  localparam int CW    = 4;
  localparam int ACC_W = 12;
  localparam int LAT_S = N_CH + 1;
  localparam int LAT_D = N_CH + ACC_W + 1;

  logic               clk = 1'b0;
  logic               nrst;
  logic               sample_strobe;
  logic [N_CH*SW-1:0] samples;
  logic [N_CH-1:0]    sample_enable;
  logic [1:0]         mode;
  logic               overrun_clr;
  logic [ACC_W-1:0]   mix_out;
  logic               mix_valid;
  logic [CW-1:0]      num_signals;
  logic               busy;
  logic               overrun;

  mixer_seq_accum dut (
    .clk          (clk),
    .nrst         (nrst),
    .sample_strobe(sample_strobe),
    .samples      (samples),
    .sample_enable(sample_enable),
    .mode         (mode),
    .overrun_clr  (overrun_clr),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .num_signals  (num_signals),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ACC_W-1:0] out;
    logic [CW-1:0]    n;
    int               due;
    string            name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every mix_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mix_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_valid: got mix_out=%0h at cycle %0d, expected no result", mix_out, cyc);
      end else begin
        e = sb.pop_front();
        $display("[TB] %s: mix_out=%0h num_signals=%0d cycle=%0d", e.name, mix_out, num_signals, cyc);
        check({e.name, "_out"}, 32'(mix_out), 32'(e.out));
        check({e.name, "_num"}, 32'(num_signals), 32'(e.n));
        check({e.name, "_latency"}, cyc, e.due);
        check({e.name, "_busy"}, 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a negedge: the strobe is taken at the next edge.
  task automatic issue(input logic [1:0] m, input logic [ACC_W-1:0] eo, input logic [CW-1:0] en,
                       input int lat, input string name);
    exp_t e;
    e.out = eo; e.n = en; e.due = cyc + 1 + lat; e.name = name;
    sb.push_back(e);
    mode = m;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic fill(input logic [SW-1:0] v);
    for (int k = 0; k < N_CH; k++) samples[k*SW +: SW] = v;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; sample_strobe = 1'b0; samples = '0; sample_enable = '0;
    mode = 2'b00; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mix_out", 32'(mix_out), 32'd0);
    check("reset_mix_valid", 32'(mix_valid), 32'd0);
    check("reset_num", 32'(num_signals), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 12 x 255 = 3060
    fill(8'hFF); sample_enable = '1;
    issue(2'b00, 12'hBF4, 4'd12, LAT_S, "sum_all_ff");
    wait_drain("sum_all_ff");
    issue(2'b01, 12'h0FF, 4'd12, LAT_S, "sat_all_ff");
    wait_drain("sat_all_ff");

    fill(8'h77); samples[0*SW +: SW] = 8'h10; samples[1*SW +: SW] = 8'h20;
    sample_enable = 12'b0000_0000_0011;
    issue(2'b01, 12'h030, 4'd2, LAT_S, "sat_two");
    wait_drain("sat_two");

    // (100 + 51 + 0) / 3 = 50
    fill(8'h55); samples[0*SW +: SW] = 8'd100; samples[3*SW +: SW] = 8'd51; samples[7*SW +: SW] = 8'd0;
    sample_enable = 12'b0000_1000_1001;
    issue(2'b10, 12'd50, 4'd3, LAT_D, "avg_three");
    wait_drain("avg_three");

    fill(8'h33); samples[5*SW +: SW] = 8'd77; sample_enable = 12'b0000_0010_0000;
    issue(2'b10, 12'd77, 4'd1, LAT_S, "avg_single");
    wait_drain("avg_single");

    sample_enable = '0;
    issue(2'b11, 12'd0, 4'd0, LAT_S, "avg_none");
    wait_drain("avg_none");

    // (7 + 4) / 2 = 5, smallest count that uses the divider
    fill(8'h00); samples[0*SW +: SW] = 8'd7; samples[1*SW +: SW] = 8'd4; sample_enable = 12'b0000_0000_0011;
    issue(2'b11, 12'd5, 4'd2, LAT_D, "avg_two");
    wait_drain("avg_two");

    // Busy strobe with changed samples: result uses the snapshot (12 x 0x11 = 0xCC)
    fill(8'h11); sample_enable = '1;
    issue(2'b00, 12'h0CC, 4'd12, LAT_S, "overrun_mix");
    repeat (3) @(negedge clk);
    fill(8'hFF); sample_enable = 12'h001; mode = 2'b01;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_drain("overrun_mix");
    check("overrun_sticky", 32'(overrun), 32'd1);

    sample_enable = '1;
    issue(2'b00, 12'hBF4, 4'd12, LAT_S, "overrun_clr_mix");
    repeat (2) @(negedge clk);
    sample_strobe = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0; overrun_clr = 1'b0;
    check("overrun_set_wins", 32'(overrun), 32'd1);
    wait_drain("overrun_clr_mix");
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);

    // Held strobe: accept edge, N_CH accumulate edges, FINISH edge -> period N_CH+2
    for (int k = 0; k < N_CH; k++) samples[k*SW +: SW] = 8'(k + 1);
    sample_enable = '1; mode = 2'b00;
    begin
      exp_t e;
      for (int r = 0; r < 3; r++) begin
        e.out = 12'h04E; e.n = 4'd12; e.due = cyc + 1 + LAT_S + r * (N_CH + 2);
        e.name = $sformatf("held_%0d", r);
        sb.push_back(e);
      end
    end
    sample_strobe = 1'b1;
    repeat (2 * (N_CH + 2) + LAT_S + 1) @(negedge clk);
    sample_strobe = 1'b0;
    wait_drain("held");
    check("held_overrun", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Abort an average mix with reset: everything clears, no result appears
    fill(8'hFF); sample_enable = '1; mode = 2'b10;
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_overrun", 32'(overrun), 32'd1);
    #1 nrst = 1'b0;
    #1;
    check("abort_mix_out", 32'(mix_out), 32'd0);
    check("abort_num", 32'(num_signals), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    check("abort_valid", 32'(mix_valid), 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (30) @(negedge clk);

    // 3060 / 12 = 255
    issue(2'b10, 12'h0FF, 4'd12, LAT_D, "post_reset_avg");
    wait_drain("post_reset_avg");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
